// File: rtl/operand_fetch_pkg.sv
// Shared types and default widths for the
// operand fetch and compute datapath.
package operand_fetch_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } of_state_e;

endpackage

// File: rtl/fetch_addr_gen.sv
// Base capture and wrap-around RAM/ROM read
// address counters for the operand stream.
module fetch_addr_gen
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [ADDR_W-1:0] ram_base_i,
    input  logic [ADDR_W-1:0] rom_base_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;

    always_comb begin
        ram_addr_d = ram_addr_q;
        rom_addr_d = rom_addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        if (load_i) begin
            ram_addr_d = ram_base_i;
            rom_addr_d = rom_base_i;
            cnt_d      = '0;
            len_d      = len_i;
        end else if (adv_i) begin
            // plain ADDR_W-bit adds give the wrap for free
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            cnt_d      = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_addr_q <= '0;
            rom_addr_q <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            rom_addr_q <= rom_addr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign rom_addr_o = rom_addr_q;
    assign last_o     = (cnt_q == len_q - ADDR_W'(1));

endmodule

// File: rtl/operand_fetch.sv
// Streams operand pairs from synchronous RAM/ROM
// into the compute unit for one dot product.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] ram_base,
    input  logic [ADDR_W-1:0] rom_base,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] rom_out,
    output logic              enable,
    output logic              acc_clr,
    output logic              busy,
    output logic              done
);

    of_state_e state_q, state_d;
    logic      drain_q, drain_d;
    logic      accept;
    logic      last;
    logic      load;
    logic      adv;

    logic              acc_clr_q;
    logic              rd_vld_q;
    logic              enable_q;
    logic [DATA_W-1:0] ram_out_q;
    logic [DATA_W-1:0] rom_out_q;

    assign accept = (state_q == S_IDLE) && start;
    assign load   = accept && (len != '0);
    assign adv    = (state_q == S_ISSUE) && !last;

    fetch_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .adv_i     (adv),
        .len_i     (len),
        .ram_base_i(ram_base),
        .rom_base_i(rom_base),
        .ram_addr_o(ram_addr),
        .rom_addr_o(rom_addr),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_ISSUE;
                    drain_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (last) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // two cycles: memory latency, then output register
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_clr_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            enable_q  <= 1'b0;
            ram_out_q <= '0;
            rom_out_q <= '0;
        end else begin
            acc_clr_q <= accept;
            rd_vld_q  <= (state_q == S_ISSUE);
            enable_q  <= rd_vld_q;
            if (rd_vld_q) begin
                ram_out_q <= ram_data;
                rom_out_q <= rom_data;
            end
        end
    end

    assign ram_out = ram_out_q;
    assign rom_out = rom_out_q;
    assign enable  = enable_q;
    assign acc_clr = acc_clr_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter ADDR_W, default 4, sets the RAM/ROM address width.
REQ-002 Parameter DATA_W, default 4, sets the operand width on ram_out/rom_out.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to begin a dot-product stream; sampled only in IDLE.
REQ-006 len  input  ADDR_W  element count L, sampled with start.
REQ-007 ram_base, rom_base  input  ADDR_W each  first RAM (activation) and ROM (weight) addresses, sampled with start.
REQ-008 ram_addr, rom_addr  output  ADDR_W each  registered read addresses to synchronous memories.
REQ-009 ram_data, rom_data  input  DATA_W each  memory read data, valid exactly one cycle after the address.
REQ-010 ram_out, rom_out  output  DATA_W each  registered operands to the compute unit.
REQ-011 enable  output  1  high while ram_out/rom_out carry a valid operand pair.
REQ-012 acc_clr  output  1  one-cycle pulse telling compute to clear its accumulator.
REQ-013 busy  output  1  high from acceptance through the done cycle inclusive.
REQ-014 done  output  1  one-cycle pulse when the stream is complete.

Function
REQ-015 States: IDLE, ISSUE, DRAIN, DONE; encoding is free, one-hot not required.
REQ-016 In IDLE with start=1 (cycle T): capture len/bases; next state ISSUE if L>0, else DONE.
REQ-017 acc_clr pulses in cycle T+1 for every accepted start, including L=0.
REQ-018 In ISSUE, cycle T+1+k (k=0..L-1): ram_addr=ram_base+k, rom_addr=rom_base+k, modulo 2^ADDR_W (wrap, no error).
REQ-019 After the address for k=L-1, ISSUE -> DRAIN; DRAIN lasts 2 cycles to absorb memory latency and the output register.
REQ-020 ram_out/rom_out register ram_data/rom_data; pair k appears in cycle T+3+k with enable=1.
REQ-021 enable is high for exactly L contiguous cycles, T+3..T+2+L; low otherwise.
REQ-022 ram_out/rom_out hold their last value when enable=0.
REQ-023 DONE lasts one cycle: done=1 at T+3+L (L>0) or T+1 (L=0); then IDLE.
REQ-024 busy=1 from T+1 through the done cycle; start while busy is ignored, not queued.
REQ-025 start asserted in the done cycle is ignored; start in the following cycle (IDLE) is accepted.
REQ-026 Addresses hold their last value outside ISSUE.
REQ-027 len/base inputs changing while busy have no effect.

Reset
REQ-028 rst=0 at a rising edge forces IDLE, all outputs 0 (addresses, operands, enable, acc_clr, busy, done) the next cycle.
REQ-029 Reset mid-stream aborts it: no further enable or done pulse; start is accepted in the first cycle with rst=1.

Structure
REQ-030 A shared package holds the state enumeration and the ADDR_W/DATA_W defaults used by compute and operand_fetch.
REQ-031 One sub-module, fetch_addr_gen, holds the base registers and wrap-around address counters; the FSM and output registers stay in operand_fetch.

Verification
REQ-032 Bench models 1-cycle synchronous RAM/ROM with mem[i]=i (RAM) and 15-i (ROM).
REQ-033 start, L=7, bases 0/0 -> acc_clr at T+1; enable T+3..T+9; pairs (0,15),(1,14)..(6,9); done at T+10; busy T+1..T+10.
REQ-034 L=3, ram_base=14, rom_base=15 -> ram_addr 14,15,0; rom_addr 15,0,1; operands (14,0),(15,15),(0,14).
REQ-035 L=0 -> acc_clr and done both at T+1, enable never high, busy only at T+1.
REQ-036 start held high continuously with L=2 -> streams back-to-back; second accepted at T+6 (first IDLE cycle after done), never during busy.
REQ-037 rst=0 at T+4 of an L=5 stream -> all outputs 0 at T+5; no done; new start at T+5 with rst=1 runs a full stream.
